// File: rtl/video_pkg.sv
// Shared timing constants, pattern encoding and bar colours for the video source.
package video_pkg;

  // 640x480@60, 25.175 MHz pixel clock
  localparam int H_ACTIVE_640 = 640;
  localparam int H_FP_640     = 16;
  localparam int H_SYNC_640   = 96;
  localparam int H_BP_640     = 48;
  localparam int V_ACTIVE_480 = 480;
  localparam int V_FP_480     = 10;
  localparam int V_SYNC_480   = 2;
  localparam int V_BP_480     = 33;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'b00,
    PAT_RAMP  = 2'b01,
    PAT_CHECK = 2'b10,
    PAT_ANIM  = 2'b11
  } pattern_e;

  localparam logic [23:0] COL_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] COL_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] COL_CYAN    = 24'h00FFFF;
  localparam logic [23:0] COL_GREEN   = 24'h00FF00;
  localparam logic [23:0] COL_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] COL_RED     = 24'hFF0000;
  localparam logic [23:0] COL_BLUE    = 24'h0000FF;
  localparam logic [23:0] COL_BLACK   = 24'h000000;

  // Bar colour by index, left to right
  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] col;
    case (idx)
      3'd0:    col = COL_WHITE;
      3'd1:    col = COL_YELLOW;
      3'd2:    col = COL_CYAN;
      3'd3:    col = COL_GREEN;
      3'd4:    col = COL_MAGENTA;
      3'd5:    col = COL_RED;
      3'd6:    col = COL_BLUE;
      default: col = COL_BLACK;
    endcase
    return col;
  endfunction

endpackage

// File: rtl/video_counter.sv
// Raster h/v counters with combinational sync, active and frame-start decode.
// All decode outputs describe the pixel the counters hold this cycle; the
// parent registers them so every output lines up.
module video_counter
  import video_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_640,
  parameter int H_FP     = H_FP_640,
  parameter int H_SYNC   = H_SYNC_640,
  parameter int H_BP     = H_BP_640,
  parameter int V_ACTIVE = V_ACTIVE_480,
  parameter int V_FP     = V_FP_480,
  parameter int V_SYNC   = V_SYNC_480,
  parameter int V_BP     = V_BP_480
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [11:0] h_cnt,
  output logic [11:0] v_cnt,
  output logic        line_end,
  output logic        frame_end,
  output logic        hs_on,
  output logic        vs_on,
  output logic        active,
  output logic        frame_start
);

  // 13-bit compare constants so a sync window ending exactly at 4096 still works
  localparam logic [12:0] H_ACT    = 13'(H_ACTIVE);
  localparam logic [12:0] HS_START = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] HS_END   = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [12:0] H_LAST   = 13'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [12:0] V_ACT    = 13'(V_ACTIVE);
  localparam logic [12:0] VS_START = 13'(V_ACTIVE + V_FP);
  localparam logic [12:0] VS_END   = 13'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [12:0] V_LAST   = 13'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  logic [11:0] h_cnt_q, h_cnt_d;
  logic [11:0] v_cnt_q, v_cnt_d;
  logic [12:0] h_ext, v_ext;

  // Next-count and window decode for the current pixel
  always_comb begin
    h_ext       = {1'b0, h_cnt_q};
    v_ext       = {1'b0, v_cnt_q};
    line_end    = (h_ext == H_LAST);
    frame_end   = line_end && (v_ext == V_LAST);
    h_cnt_d     = line_end ? 12'd0 : h_cnt_q + 12'd1;
    v_cnt_d     = v_cnt_q;
    if (frame_end) begin
      v_cnt_d = 12'd0;
    end else if (line_end) begin
      v_cnt_d = v_cnt_q + 12'd1;
    end
    hs_on       = (h_ext >= HS_START) && (h_ext < HS_END);
    vs_on       = (v_ext >= VS_START) && (v_ext < VS_END);
    active      = (h_ext < H_ACT) && (v_ext < V_ACT);
    frame_start = (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);
  end

  // Counter state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q <= 12'd0;
      v_cnt_q <= 12'd0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign h_cnt = h_cnt_q;
  assign v_cnt = v_cnt_q;

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing and test-pattern source for the TMDS encoders: pattern latch,
// frame counter, pattern mux and a single aligned output register stage.
module video_timing_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_640,
  parameter int H_FP     = H_FP_640,
  parameter int H_SYNC   = H_SYNC_640,
  parameter int H_BP     = H_BP_640,
  parameter int V_ACTIVE = V_ACTIVE_480,
  parameter int V_FP     = V_FP_480,
  parameter int V_SYNC   = V_SYNC_480,
  parameter int V_BP     = V_BP_480,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  pattern_sel,
  output logic        hsync,
  output logic        vsync,
  output logic        active,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        frame_start,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic [1:0]  ctrl0
);

  localparam logic [11:0] BAR_LAST = 12'(H_ACTIVE / 8 - 1);

  logic [11:0] c_h, c_v;
  logic        c_line_end, c_frame_end, c_hs_on, c_vs_on, c_active, c_frame_start;

  video_counter #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_counter (
    .clk         (clk),
    .rst_n       (rst_n),
    .h_cnt       (c_h),
    .v_cnt       (c_v),
    .line_end    (c_line_end),
    .frame_end   (c_frame_end),
    .hs_on       (c_hs_on),
    .vs_on       (c_vs_on),
    .active      (c_active),
    .frame_start (c_frame_start)
  );

  pattern_e    pat_q, pat_d, pat_eff;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic [11:0] bar_rem_q, bar_rem_d;
  logic [2:0]  bar_idx_q, bar_idx_d;
  logic        hsync_q, hsync_d, vsync_q, vsync_d, active_q, active_d;
  logic        frame_start_q, frame_start_d;
  logic [11:0] x_q, x_d, y_q, y_d;
  logic [23:0] rgb_q, rgb_d;

  // Pattern selection, frame counter, bar tracking and pixel colour
  always_comb begin
    // At (0,0) the new request is used immediately so pixel (0,0) already
    // belongs to the new frame's pattern; otherwise the latched one holds.
    pat_eff     = c_frame_start ? pattern_e'(pattern_sel) : pat_q;
    pat_d       = pat_eff;
    frame_cnt_d = c_frame_end ? frame_cnt_q + 8'd1 : frame_cnt_q;

    // Bar-width down-counter aligned to the pixel the counters hold
    bar_rem_d = bar_rem_q - 12'd1;
    bar_idx_d = bar_idx_q;
    if (c_line_end) begin
      bar_rem_d = BAR_LAST;
      bar_idx_d = 3'd0;
    end else if (bar_rem_q == 12'd0) begin
      bar_rem_d = BAR_LAST;
      if (bar_idx_q != 3'd7) bar_idx_d = bar_idx_q + 3'd1;
    end

    x_d = c_active ? c_h : 12'd0;
    y_d = c_active ? c_v : 12'd0;

    case (pat_eff)
      PAT_BARS:  rgb_d = bar_colour(bar_idx_q);
      PAT_RAMP:  rgb_d = {x_d[7:0], x_d[7:0], x_d[7:0]};
      PAT_CHECK: rgb_d = (x_d[5] ^ y_d[5]) ? COL_WHITE : COL_BLACK;
      PAT_ANIM:  rgb_d = {frame_cnt_q, y_d[7:0], x_d[7:0]};
      default:   rgb_d = COL_BLACK;
    endcase
    if (!c_active) rgb_d = COL_BLACK;

    hsync_d       = c_hs_on ? HS_POL : ~HS_POL;
    vsync_d       = c_vs_on ? VS_POL : ~VS_POL;
    active_d      = c_active;
    frame_start_d = c_frame_start;
  end

  // Pattern state and output register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q         <= PAT_BARS;
      frame_cnt_q   <= 8'd0;
      bar_rem_q     <= BAR_LAST;
      bar_idx_q     <= 3'd0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      active_q      <= 1'b0;
      frame_start_q <= 1'b0;
      x_q           <= 12'd0;
      y_q           <= 12'd0;
      rgb_q         <= 24'd0;
    end else begin
      pat_q         <= pat_d;
      frame_cnt_q   <= frame_cnt_d;
      bar_rem_q     <= bar_rem_d;
      bar_idx_q     <= bar_idx_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      active_q      <= active_d;
      frame_start_q <= frame_start_d;
      x_q           <= x_d;
      y_q           <= y_d;
      rgb_q         <= rgb_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign active      = active_q;
  assign frame_start = frame_start_q;
  assign x           = x_q;
  assign y           = y_q;
  assign red         = rgb_q[23:16];
  assign green       = rgb_q[15:8];
  assign blue        = rgb_q[7:0];
  assign ctrl0       = {vsync_q, hsync_q};

endmodule
